// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the cpu core: generates the per-cycle
// execute enable, holds the PC breakpoints and counts executed cycles.
module cpu_run_ctrl #(
    parameter int NUM_BP = 2,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic [31:0]      pc,
    input  logic             bp_we,
    input  logic [2:0]       bp_idx,
    input  logic [31:0]      bp_addr,
    input  logic             bp_en,
    input  logic             cnt_clr,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [2:0]       bp_hit_idx,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               skip_q, skip_d;
    logic               bp_hit_q, bp_hit_d;
    logic [2:0]         bp_hit_idx_q, bp_hit_idx_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [29:0]        bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0]  bp_en_q;

    logic [NUM_BP-1:0]  hit_vec_s;
    logic               bp_match_s;
    logic [2:0]         bp_match_idx_s;
    logic               bp_stop_s;
    logic               cpu_en_s;
    logic               unused_s;

    // Breakpoints compare word addresses only, so the byte-offset bits are dropped.
    assign unused_s = ^{pc[1:0], bp_addr[1:0]};

    // Breakpoint compare and lowest-index priority select.
    always_comb begin
        hit_vec_s      = '0;
        bp_match_idx_s = 3'd0;
        for (int i = 0; i < NUM_BP; i++) begin
            hit_vec_s[i] = bp_en_q[i] && (bp_addr_q[i] == pc[31:2]);
        end
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            bp_match_idx_s = hit_vec_s[i] ? 3'(i) : bp_match_idx_s;
        end
        bp_match_s = |hit_vec_s;
    end

    // Run-state next-state logic and execute enable.
    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        bp_hit_d     = bp_hit_q;
        bp_hit_idx_d = bp_hit_idx_q;
        cpu_en_s     = 1'b0;
        bp_stop_s    = bp_match_s && !skip_q;
        case (state_q)
            ST_HALT: begin
                cpu_en_s = 1'b0;
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (step_req) begin
                    state_d  = ST_STEP;
                    skip_d   = 1'b1;
                    bp_hit_d = 1'b0;
                end else if (run_req) begin
                    state_d  = ST_RUN;
                    skip_d   = 1'b1;
                    bp_hit_d = 1'b0;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                cpu_en_s = 1'b1;
                skip_d   = 1'b0;
                state_d  = ST_HALT;
            end
            ST_RUN: begin
                // A stop only happens with skip already clear, so skip always ends cleared.
                cpu_en_s = !bp_stop_s;
                skip_d   = 1'b0;
                if (bp_stop_s) begin
                    state_d      = ST_HALT;
                    bp_hit_d     = 1'b1;
                    bp_hit_idx_d = bp_match_idx_s;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                cpu_en_s = 1'b0;
                state_d  = ST_HALT;
            end
        endcase
    end

    // Executed-cycle counter next value; clear overrides increment.
    always_comb begin
        if (cnt_clr) begin
            cycle_cnt_d = '0;
        end else if (cpu_en_s) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
    end

    // Control and counter state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_HALT;
            skip_q       <= 1'b0;
            bp_hit_q     <= 1'b0;
            bp_hit_idx_q <= 3'd0;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            bp_hit_q     <= bp_hit_d;
            bp_hit_idx_q <= bp_hit_idx_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    // Breakpoint register file; out-of-range indices are dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bp_en_q <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= 30'd0;
            end
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_we && (bp_idx == 3'(i))) begin
                    bp_addr_q[i] <= bp_addr[31:2];
                    bp_en_q[i]   <= bp_en;
                end
            end
        end
    end

    assign cpu_en     = cpu_en_s;
    assign state      = state_q;
    assign bp_hit     = bp_hit_q;
    assign bp_hit_idx = bp_hit_idx_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed plus randomized bench for cpu_run_ctrl against a behavioural
// run/step/breakpoint model; uses a 4-bit counter so wrap is reachable.
module tb_cpu_run_ctrl;

    localparam int NUM_BP = 2;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             run_req, step_req, halt_req;
    logic [31:0]      pc;
    logic             bp_we;
    logic [2:0]       bp_idx;
    logic [31:0]      bp_addr;
    logic             bp_en;
    logic             cnt_clr;
    logic             cpu_en;
    logic [1:0]       state;
    logic             bp_hit;
    logic [2:0]       bp_hit_idx;
    logic [CNT_W-1:0] cycle_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=halted, 1=running, 2=single step
    int          m_mode;
    bit          m_skip;
    bit          m_hit;
    int          m_idx;
    int          m_cnt;
    logic [31:0] m_addr [NUM_BP];
    bit          m_ben  [NUM_BP];
    bit          last_en;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.NUM_BP(NUM_BP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .run_req(run_req), .step_req(step_req),
        .halt_req(halt_req), .pc(pc), .bp_we(bp_we), .bp_idx(bp_idx),
        .bp_addr(bp_addr), .bp_en(bp_en), .cnt_clr(cnt_clr), .cpu_en(cpu_en),
        .state(state), .bp_hit(bp_hit), .bp_hit_idx(bp_hit_idx), .cycle_cnt(cycle_cnt)
    );

    function automatic int lowest_match();
        for (int i = 0; i < NUM_BP; i++) begin
            if (m_ben[i] && ((m_addr[i] / 4) == (pc / 4))) return i;
        end
        return -1;
    endfunction

    function automatic bit model_en();
        if (m_mode == 2) return 1'b1;
        if (m_mode == 1) return !((lowest_match() >= 0) && !m_skip);
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".cpu_en"}, {31'd0, cpu_en}, {31'd0, model_en()});
        chk({tag, ".state"}, {30'd0, state}, 32'(m_mode));
        chk({tag, ".bp_hit"}, {31'd0, bp_hit}, {31'd0, m_hit});
        chk({tag, ".bp_hit_idx"}, {29'd0, bp_hit_idx}, 32'(m_idx));
        chk({tag, ".cycle_cnt"}, {28'd0, cycle_cnt}, 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_mode = 0; m_skip = 1'b0; m_hit = 1'b0; m_idx = 0; m_cnt = 0;
        for (int i = 0; i < NUM_BP; i++) begin
            m_addr[i] = 32'd0;
            m_ben[i]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit en;
        int mi;
        en = model_en();
        mi = lowest_match();
        last_en = en;
        if (cnt_clr) m_cnt = 0;
        else if (en) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (en) m_skip = 1'b0;
        case (m_mode)
            0: begin
                if (!halt_req && step_req) begin
                    m_mode = 2; m_skip = 1'b1; m_hit = 1'b0;
                end else if (!halt_req && run_req) begin
                    m_mode = 1; m_skip = 1'b1; m_hit = 1'b0;
                end
            end
            1: begin
                if (!en) begin
                    m_mode = 0; m_hit = 1'b1; m_idx = mi;
                end else if (halt_req) begin
                    m_mode = 0;
                end
            end
            default: m_mode = 0;
        endcase
        if (bp_we && (int'(bp_idx) < NUM_BP)) begin
            m_addr[bp_idx] = bp_addr;
            m_ben[bp_idx]  = bp_en;
        end
    endtask

    // Caller sets inputs just after a falling edge; the simulated cpu advances pc on executed cycles.
    task automatic tick(input string tag);
        #1 check_model(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; bp_we = 1'b0; cnt_clr = 1'b0;
        if (last_en) pc = pc + 32'd4;
    endtask

    task automatic bpw(input int idx, input logic [31:0] addr, input bit en);
        bp_we = 1'b1; bp_idx = 3'(idx); bp_addr = addr; bp_en = en;
        tick("bpw");
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        model_reset();
        #1 check_model(tag);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        pc = 32'd0; bp_we = 1'b0; bp_idx = 3'd0; bp_addr = 32'd0; bp_en = 1'b0;
        cnt_clr = 1'b0; last_en = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset("reset");
        chk("reset.state", {30'd0, state}, 32'd0);
        chk("reset.cycle_cnt", {28'd0, cycle_cnt}, 32'd0);

        // single step
        pc = 32'h0; step_req = 1'b1;
        tick("t1.req");
        #1 chk("t1.state", {30'd0, state}, 32'd2);
        chk("t1.cpu_en", {31'd0, cpu_en}, 32'd1);
        tick("t1.step");
        #1 chk("t1.halt", {30'd0, state}, 32'd0);
        chk("t1.cnt", {28'd0, cycle_cnt}, 32'd1);

        // run into breakpoint at 0x10, both entries matching
        cnt_clr = 1'b1; tick("t2.clr");
        bpw(0, 32'h10, 1'b1);
        bpw(1, 32'h10, 1'b1);
        pc = 32'h0; run_req = 1'b1;
        tick("t2.run");
        repeat (4) tick("t2.exec");
        #1 chk("t2.pc_bp_en", {31'd0, cpu_en}, 32'd0);
        tick("t2.bp");
        #1 chk("t2.state", {30'd0, state}, 32'd0);
        chk("t2.bp_hit", {31'd0, bp_hit}, 32'd1);
        chk("t2.bp_hit_idx", {29'd0, bp_hit_idx}, 32'd0);
        chk("t2.cnt", {28'd0, cycle_cnt}, 32'd4);

        // resume from breakpoint pc: skip lets it execute
        run_req = 1'b1;
        tick("t3.run");
        #1 chk("t3.cpu_en", {31'd0, cpu_en}, 32'd1);
        chk("t3.bp_hit", {31'd0, bp_hit}, 32'd0);
        tick("t3.skip");
        #1 chk("t3.state", {30'd0, state}, 32'd1);
        tick("t3.cont");

        // halt_req at pc=0x8 with no breakpoint
        pc = 32'h0;
        tick("t4.pc0");
        tick("t4.pc4");
        halt_req = 1'b1;
        #1 chk("t4.halt_cycle_en", {31'd0, cpu_en}, 32'd1);
        tick("t4.halt");
        #1 chk("t4.en_after", {31'd0, cpu_en}, 32'd0);
        chk("t4.state", {30'd0, state}, 32'd0);
        chk("t4.bp_hit", {31'd0, bp_hit}, 32'd0);

        // halt_req coinciding with bp1 match: breakpoint wins
        bpw(0, 32'h10, 1'b0);
        pc = 32'hC; run_req = 1'b1;
        tick("t5.run");
        tick("t5.pcC");
        halt_req = 1'b1;
        #1 chk("t5.en", {31'd0, cpu_en}, 32'd0);
        tick("t5.both");
        #1 chk("t5.state", {30'd0, state}, 32'd0);
        chk("t5.bp_hit", {31'd0, bp_hit}, 32'd1);
        chk("t5.bp_hit_idx", {29'd0, bp_hit_idx}, 32'd1);

        // counter wrap, clear during execution, out-of-range bp writes ignored
        bpw(1, 32'h10, 1'b0);
        bpw(3, 32'h40, 1'b1);
        bpw(2, 32'h8, 1'b1);
        cnt_clr = 1'b1; tick("t6.clr");
        pc = 32'h0; run_req = 1'b1;
        tick("t6.run");
        repeat (17) tick("t6.exec");
        #1 chk("t6.wrap", {28'd0, cycle_cnt}, 32'd1);
        chk("t6.state", {30'd0, state}, 32'd1);
        cnt_clr = 1'b1;
        tick("t6.clr_en");
        #1 chk("t6.cleared", {28'd0, cycle_cnt}, 32'd0);
        tick("t6.more");
        #1 chk("t6.pre_rst_en", {31'd0, cpu_en}, 32'd1);
        do_reset("t6.async_rst");
        chk("t6.rst_en", {31'd0, cpu_en}, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            run_req  = ($urandom_range(0, 5) == 0);
            step_req = ($urandom_range(0, 7) == 0);
            halt_req = ($urandom_range(0, 9) == 0);
            cnt_clr  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 5) == 0) begin
                bp_we   = 1'b1;
                bp_idx  = 3'($urandom_range(0, 3));
                bp_addr = 32'($urandom_range(0, 63));
                bp_en   = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 7) == 0) pc = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 149) == 0) do_reset("rnd.rst");
            else tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
